// File: rtl/rpn_stack_controller.sv
// rpn_stack_controller: operand stack + sequencer for the RPN calculator.
// Enter pushes DataIn (OpMode=0) or runs a READY->FETCH->EXEC->WRITE pass
// through the external ALU (OpMode=1); Undo reverts the last push/op once.
// Optional macro RPN_ERR_STICKY_EN: Error stays set until reset.
module rpn_stack_controller #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EnterPulse,
  input  logic             UndoPulse,
  input  logic             OpMode,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0] AluResult,
  input  logic [4:0]       AluFlags,
  output logic [WIDTH-1:0] OpA,
  output logic [WIDTH-1:0] OpB,
  output logic [1:0]       OpCode,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       Flags,
  output logic [WIDTH-1:0] Top,
  output logic [DW-1:0]    Depth,
  output logic [2:0]       Status,
  output logic             ToDisplaySel,
  output logic             Error
);

  typedef enum logic [2:0] {READY = 3'd0, FETCH = 3'd1, EXEC = 3'd2, WRITE = 3'd3} state_t;
  typedef enum logic [1:0] {U_NONE = 2'd0, U_PUSH = 2'd1, U_OP = 2'd2} undo_t;

  state_t           state_q, state_d;
  undo_t            urec_q, urec_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [WIDTH-1:0] sava_q, sava_d, savb_q, savb_d;
  logic [1:0]       opc_q, opc_d, pend_q, pend_d;
  logic [4:0]       flg_q, flg_d;
  logic             sel_q, sel_d, err_q, err_d, err_ok;
  logic [AW-1:0]    ix0, ix1, ix2;

  // Slot indices relative to the current fill level (first free, top, second).
  assign ix0 = AW'(depth_q);
  assign ix1 = AW'(depth_q - DW'(1));
  assign ix2 = AW'(depth_q - DW'(2));

  // Value Error takes after a successful action.
`ifdef RPN_ERR_STICKY_EN
  assign err_ok = err_q;
`else
  assign err_ok = 1'b0;
`endif

  // Next-state and datapath updates; pulses only matter in READY, Undo wins over Enter.
  always_comb begin
    state_d = state_q;
    urec_d  = urec_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    pend_d  = pend_q;
    res_d   = res_q;
    flg_d   = flg_q;
    sava_d  = sava_q;
    savb_d  = savb_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      READY: begin
        if (UndoPulse) begin
          case (urec_q)
            U_OP: begin
              stk_d[ix1] = sava_q;
              stk_d[ix0] = savb_q;
              depth_d    = depth_q + DW'(1);
              urec_d     = U_NONE;
              err_d      = err_ok;
            end
            U_PUSH: begin
              depth_d = depth_q - DW'(1);
              urec_d  = U_NONE;
              err_d   = err_ok;
            end
            default: err_d = 1'b1;
          endcase
        end else if (EnterPulse) begin
          if (!OpMode) begin
            if (depth_q == DW'(DEPTH)) begin
              err_d = 1'b1;
            end else begin
              stk_d[ix0] = DataIn;
              depth_d    = depth_q + DW'(1);
              sel_d      = 1'b0;
              urec_d     = U_PUSH;
              err_d      = err_ok;
            end
          end else if (depth_q < DW'(2)) begin
            err_d = 1'b1;
          end else begin
            // Opcode held until FETCH in case DataIn moves after the pulse.
            pend_d  = DataIn[1:0];
            state_d = FETCH;
            err_d   = err_ok;
          end
        end
      end
      FETCH: begin
        opa_d   = stk_q[ix2];
        opb_d   = stk_q[ix1];
        opc_d   = pend_q;
        sava_d  = stk_q[ix2];
        savb_d  = stk_q[ix1];
        urec_d  = U_OP;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = AluResult;
        flg_d   = AluFlags;
        sel_d   = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        stk_d[ix2] = res_q;
        depth_d    = depth_q - DW'(1);
        state_d    = READY;
      end
      default: state_d = READY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= READY;
    else       state_q <= state_d;
  end

  // Stack, operand, result and undo registers; reset discards any partial op.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      urec_q  <= U_NONE;
      depth_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      pend_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      sava_q  <= '0;
      savb_q  <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      urec_q  <= urec_d;
      depth_q <= depth_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      sava_q  <= sava_d;
      savb_q  <= savb_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign OpA          = opa_q;
  assign OpB          = opb_q;
  assign OpCode       = opc_q;
  assign Result       = res_q;
  assign Flags        = flg_q;
  assign Depth        = depth_q;
  assign Status       = state_q;
  assign ToDisplaySel = sel_q;
  assign Error        = err_q;
  assign Top          = (depth_q == '0) ? '0 : stk_q[ix1];

endmodule
